// File: rtl/tb_cmd_executor.sv
// -----------------------------------------------------------------------------
// tb_cmd_executor
//
// Executes decoded scenario commands one at a time against a device under
// test. The upstream sequencer presents a command (opcode, signal selector,
// data) with cmd_valid and holds it until cmd_ack. Each command either drives
// one of the set_o lines, waits for a level on one of the wait_i lines (with a
// timeout), waits a number of cycles, checks a level on a wait_i line, or ends
// the test.
//
// Ports
//   clk          clock
//   rst          asynchronous reset, active-high (synchronous release expected)
//   cmd_valid    command present, held stable until cmd_ack
//   cmd_opcode   0 NOP, 1 SET, 2 WAIT_EVENT, 3 WAIT_DURATION, 4 CHECK,
//                5 END_TEST, 6-15 illegal
//   cmd_sel      signal index into set_o / wait_i
//   cmd_data     bit0 = level (SET/WAIT_EVENT/CHECK), full value = cycle count
//                (WAIT_DURATION)
//   cmd_ack      one-cycle completion pulse
//   wait_i       observed DUT signals, synchronous to clk
//   set_o        driven DUT signals (registered)
//   busy         high while a WAIT_EVENT or WAIT_DURATION is in progress
//   done         sticky, END_TEST has executed
//   err_cnt      saturating count of CHECK mismatches
//   timeout_err  sticky, a WAIT_EVENT timed out
//   illegal_err  sticky, illegal opcode or out-of-range selector
// -----------------------------------------------------------------------------
module tb_cmd_executor #(
  parameter int                NB_SIG      = 8,
  parameter int                CNT_W       = 32,
  parameter int                TIMEOUT_CYC = 1000,
  parameter int                ERR_W       = 16,
  parameter logic [NB_SIG-1:0] SET_INIT    = '0,
  // One bit wider than a bare index so that out-of-range selectors
  // (e.g. 8 with eight signals) can be presented and flagged.
  parameter int                SEL_W       = ($clog2(NB_SIG + 1) > 1) ? $clog2(NB_SIG + 1) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  input  logic [3:0]        cmd_opcode,
  input  logic [SEL_W-1:0]  cmd_sel,
  input  logic [CNT_W-1:0]  cmd_data,
  output logic              cmd_ack,
  input  logic [NB_SIG-1:0] wait_i,
  output logic [NB_SIG-1:0] set_o,
  output logic              busy,
  output logic              done,
  output logic [ERR_W-1:0]  err_cnt,
  output logic              timeout_err,
  output logic              illegal_err
);

  localparam logic [3:0] OP_NOP           = 4'd0;
  localparam logic [3:0] OP_SET           = 4'd1;
  localparam logic [3:0] OP_WAIT_EVENT    = 4'd2;
  localparam logic [3:0] OP_WAIT_DURATION = 4'd3;
  localparam logic [3:0] OP_CHECK         = 4'd4;
  localparam logic [3:0] OP_END_TEST      = 4'd5;

  localparam int              TCNT_W       = ($clog2(TIMEOUT_CYC) > 0) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TCNT_W-1:0] TCNT_LAST  = TCNT_W'(TIMEOUT_CYC - 1);
  localparam logic [ERR_W-1:0]  ERR_MAX    = {ERR_W{1'b1}};
  localparam logic [SEL_W-1:0]  SEL_LIMIT  = SEL_W'(NB_SIG);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_EVT,
    ST_WAIT_DUR,
    ST_ACK,
    ST_DONE
  } state_t;

  state_t              state_reg, state_next;
  logic [NB_SIG-1:0]   set_reg, set_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [TCNT_W-1:0]   tcnt_reg, tcnt_next;
  logic [NB_SIG-1:0]   evt_mask_reg, evt_mask_next;
  logic                evt_level_reg, evt_level_next;
  logic                done_reg, done_next;
  logic [ERR_W-1:0]    err_reg, err_next;
  logic                timeout_reg, timeout_next;
  logic                illegal_reg, illegal_next;

  // One-hot decode of the incoming selector. An out-of-range selector decodes
  // to all zeros, so it can never touch set_o even before the legality check.
  logic [NB_SIG-1:0]   sel_onehot;

  genvar gi;
  generate
    for (gi = 0; gi < NB_SIG; gi++) begin : g_sel_dec
      assign sel_onehot[gi] = (cmd_sel == SEL_W'(gi));
    end
  endgenerate

  logic sel_level;   // wait_i at the incoming selector
  logic evt_level;   // wait_i at the latched WAIT_EVENT selector
  logic needs_sel;
  logic cmd_illegal;

  assign sel_level = |(wait_i & sel_onehot);
  assign evt_level = |(wait_i & evt_mask_reg);

  assign needs_sel   = (cmd_opcode == OP_SET) || (cmd_opcode == OP_CHECK) ||
                       (cmd_opcode == OP_WAIT_EVENT);
  assign cmd_illegal = (cmd_opcode > OP_END_TEST) || (needs_sel && (cmd_sel >= SEL_LIMIT));

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      set_reg       <= SET_INIT;
      cnt_reg       <= '0;
      tcnt_reg      <= '0;
      evt_mask_reg  <= '0;
      evt_level_reg <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= '0;
      timeout_reg   <= 1'b0;
      illegal_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      set_reg       <= set_next;
      cnt_reg       <= cnt_next;
      tcnt_reg      <= tcnt_next;
      evt_mask_reg  <= evt_mask_next;
      evt_level_reg <= evt_level_next;
      done_reg      <= done_next;
      err_reg       <= err_next;
      timeout_reg   <= timeout_next;
      illegal_reg   <= illegal_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and command execution
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    set_next       = set_reg;
    cnt_next       = cnt_reg;
    tcnt_next      = tcnt_reg;
    evt_mask_next  = evt_mask_reg;
    evt_level_next = evt_level_reg;
    done_next      = done_reg;
    err_next       = err_reg;
    timeout_next   = timeout_reg;
    illegal_next   = illegal_reg;

    case (state_reg)
      ST_IDLE: begin
        if (cmd_valid) begin
          // Single-cycle commands go straight to ACK; only the waits divert.
          state_next = ST_ACK;
          if (cmd_illegal) begin
            illegal_next = 1'b1;
          end else begin
            case (cmd_opcode)
              OP_SET: begin
                set_next = (set_reg & ~sel_onehot) | (sel_onehot & {NB_SIG{cmd_data[0]}});
              end
              OP_WAIT_EVENT: begin
                evt_mask_next  = sel_onehot;
                evt_level_next = cmd_data[0];
                tcnt_next      = '0;
                state_next     = ST_WAIT_EVT;
              end
              OP_WAIT_DURATION: begin
                cnt_next   = cmd_data;
                state_next = ST_WAIT_DUR;
              end
              OP_CHECK: begin
                if ((sel_level != cmd_data[0]) && (err_reg != ERR_MAX)) begin
                  err_next = err_reg + 1'b1;
                end
              end
              OP_END_TEST: begin
                done_next = 1'b1;
              end
              OP_NOP: begin
              end
              default: begin
              end
            endcase
          end
        end
      end

      ST_WAIT_EVT: begin
        // A match on the same cycle as the last timeout cycle wins.
        if (evt_level == evt_level_reg) begin
          state_next = ST_ACK;
        end else if (tcnt_reg == TCNT_LAST) begin
          timeout_next = 1'b1;
          state_next   = ST_ACK;
        end else begin
          tcnt_next = tcnt_reg + 1'b1;
        end
      end

      ST_WAIT_DUR: begin
        // Count of N yields N+1 cycles here, so N=0 still costs one cycle.
        if (cnt_reg == '0) begin
          state_next = ST_ACK;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end

      ST_ACK: begin
        // done is only ever set by END_TEST, so it selects the terminal state.
        state_next = done_reg ? ST_DONE : ST_IDLE;
      end

      ST_DONE: begin
        state_next = ST_DONE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign cmd_ack     = (state_reg == ST_ACK);
  // busy covers only the multi-cycle wait states; the one-cycle ACK state is
  // signalled by cmd_ack itself.
  assign busy        = (state_reg == ST_WAIT_EVT) || (state_reg == ST_WAIT_DUR);
  assign set_o       = set_reg;
  assign done        = done_reg;
  assign err_cnt     = err_reg;
  assign timeout_err = timeout_reg;
  assign illegal_err = illegal_reg;

endmodule
